// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared RTC register map, FSM encoding and BCD helper
// Purpose: constants and helpers shared by the RTC read path and the future write sequencer.
// Contents: register addresses, sequencer control bit positions, shadow FSM states, is_bcd().
package rtc_pkg;

    // Date/time block, read in this order
    localparam logic [7:0] ADDR_SEC   = 8'h21;
    localparam logic [7:0] ADDR_MIN   = 8'h22;
    localparam logic [7:0] ADDR_HOUR  = 8'h23;
    localparam logic [7:0] ADDR_DAY   = 8'h24;
    localparam logic [7:0] ADDR_MONTH = 8'h25;
    localparam logic [7:0] ADDR_YEAR  = 8'h26;
    // Timer block, read immediately after the date/time block
    localparam logic [7:0] ADDR_TSEC  = 8'h41;
    localparam logic [7:0] ADDR_TMIN  = 8'h42;
    localparam logic [7:0] ADDR_THOUR = 8'h43;

    localparam int unsigned NUM_SLOTS = 9;

    // Bit positions in the bus sequencer's control word
    localparam int unsigned CTL_CS_BIT = 0;
    localparam int unsigned CTL_AD_BIT = 1;
    localparam int unsigned CTL_RD_BIT = 2;
    localparam int unsigned CTL_WR_BIT = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2
    } shadow_state_e;

    function automatic logic is_bcd(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/rtc_addr_seq.sv
// rtl/rtc_addr_seq.sv - RTC register address to slot map and successor address
// Purpose: combinational decode of an RTC register address.
// Ports: addr (in, 8)      register address
//        slot (out, 4)     staging slot 0-8 for that register
//        hit (out, 1)      addr is one of the nine frame registers
//        next_addr (out,8) address read after addr (wraps to ADDR_SEC after ADDR_THOUR)
module rtc_addr_seq
    import rtc_pkg::*;
(
    input  logic [7:0] addr,
    output logic [3:0] slot,
    output logic       hit,
    output logic [7:0] next_addr
);

    always_comb begin
        slot      = 4'd0;
        hit       = 1'b1;
        next_addr = ADDR_SEC;
        case (addr)
            ADDR_SEC:   begin slot = 4'd0; next_addr = ADDR_MIN;   end
            ADDR_MIN:   begin slot = 4'd1; next_addr = ADDR_HOUR;  end
            ADDR_HOUR:  begin slot = 4'd2; next_addr = ADDR_DAY;   end
            ADDR_DAY:   begin slot = 4'd3; next_addr = ADDR_MONTH; end
            ADDR_MONTH: begin slot = 4'd4; next_addr = ADDR_YEAR;  end
            // The date block is followed by the timer block, not 0x27
            ADDR_YEAR:  begin slot = 4'd5; next_addr = ADDR_TSEC;  end
            ADDR_TSEC:  begin slot = 4'd6; next_addr = ADDR_TMIN;  end
            ADDR_TMIN:  begin slot = 4'd7; next_addr = ADDR_THOUR; end
            ADDR_THOUR: begin slot = 4'd8; next_addr = ADDR_SEC;   end
            default:    hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/rtc_shadow_regs.sv
// rtl/rtc_shadow_regs.sv - RTC read frame assembler with atomic shadow bank
// Purpose: collects the nine RTC register bytes in order, checks BCD and ordering,
//          and commits clean frames to the shadow outputs in one cycle.
// Ports: clk, reset (async active-low)
//        addr/data/data_vld - captured byte and the register it came from
//        abort              - sequencer left the read sequence; drop the frame
//        sec..year, t_sec..t_hour - committed BCD shadow bank
//        frame_valid        - one-cycle commit pulse
//        bcd_err, seq_err   - sticky error flags, cleared by a good commit
//        frame_cnt          - committed frame counter (wraps)
module rtc_shadow_regs
    import rtc_pkg::*;
#(
    parameter int unsigned TIMEOUT    = 64,
    parameter logic [7:0]  FIRST_ADDR = 8'h21,
    parameter logic [7:0]  LAST_ADDR  = 8'h43
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    input  logic       data_vld,
    input  logic       abort,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hour,
    output logic [7:0] day,
    output logic [7:0] month,
    output logic [7:0] year,
    output logic [7:0] t_sec,
    output logic [7:0] t_min,
    output logic [7:0] t_hour,
    output logic       frame_valid,
    output logic       bcd_err,
    output logic       seq_err,
    output logic [7:0] frame_cnt
);

    localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W:0] TMO_LAST = (TMO_W + 1)'(TIMEOUT - 1);

    shadow_state_e          state_q, state_d;
    logic [8:0][7:0]        stage_q, stage_d;
    logic [8:0][7:0]        shadow_q, shadow_d;
    logic [7:0]             expected_q, expected_d;
    logic                   bad_q, bad_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [TMO_W:0]         tmo_inc;
    logic                   frame_valid_q, frame_valid_d;
    logic                   bcd_err_q, bcd_err_d;
    logic                   seq_err_q, seq_err_d;
    logic [7:0]             frame_cnt_q, frame_cnt_d;

    logic [3:0]             seq_slot;
    logic                   seq_hit;
    logic [7:0]             seq_next;

    rtc_addr_seq u_addr_seq (
        .addr      (addr),
        .slot      (seq_slot),
        .hit       (seq_hit),
        .next_addr (seq_next)
    );

    assign tmo_inc = {1'b0, tmo_q} + 1'b1;

    always_comb begin
        state_d       = state_q;
        stage_d       = stage_q;
        shadow_d      = shadow_q;
        expected_d    = expected_q;
        bad_d         = bad_q;
        tmo_d         = tmo_q;
        frame_valid_d = 1'b0;
        bcd_err_d     = bcd_err_q;
        seq_err_d     = seq_err_q;
        frame_cnt_d   = frame_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (data_vld && addr == FIRST_ADDR) begin
                    stage_d[0] = data;
                    bad_d      = !is_bcd(data);
                    expected_d = seq_next;
                    tmo_d      = '0;
                    state_d    = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    expected_d = FIRST_ADDR;
                    tmo_d      = '0;
                end else if (data_vld) begin
                    tmo_d = '0;
                    if (seq_hit && addr == expected_q) begin
                        stage_d[seq_slot] = data;
                        bad_d             = bad_q | !is_bcd(data);
                        expected_d        = seq_next;
                        if (addr == LAST_ADDR) begin
                            state_d = ST_COMMIT;
                        end
                    end else if (addr == FIRST_ADDR) begin
                        // Sequencer restarted mid-frame: flag it, but keep the new frame
                        seq_err_d  = 1'b1;
                        stage_d[0] = data;
                        bad_d      = !is_bcd(data);
                        expected_d = seq_next;
                    end else begin
                        seq_err_d  = 1'b1;
                        state_d    = ST_IDLE;
                        expected_d = FIRST_ADDR;
                    end
                end else if (tmo_inc == TMO_LAST) begin
                    seq_err_d  = 1'b1;
                    state_d    = ST_IDLE;
                    expected_d = FIRST_ADDR;
                    tmo_d      = '0;
                end else begin
                    tmo_d = tmo_inc[TMO_W-1:0];
                end
            end

            ST_COMMIT: begin
                if (!bad_q) begin
                    shadow_d      = stage_q;
                    frame_valid_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + 8'd1;
                    bcd_err_d     = 1'b0;
                    seq_err_d     = 1'b0;
                end else begin
                    bcd_err_d = 1'b1;
                end
                state_d    = ST_IDLE;
                expected_d = FIRST_ADDR;
            end

            default: begin
                state_d    = ST_IDLE;
                expected_d = FIRST_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            stage_q       <= '0;
            shadow_q      <= '0;
            expected_q    <= FIRST_ADDR;
            bad_q         <= 1'b0;
            tmo_q         <= '0;
            frame_valid_q <= 1'b0;
            bcd_err_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            stage_q       <= stage_d;
            shadow_q      <= shadow_d;
            expected_q    <= expected_d;
            bad_q         <= bad_d;
            tmo_q         <= tmo_d;
            frame_valid_q <= frame_valid_d;
            bcd_err_q     <= bcd_err_d;
            seq_err_q     <= seq_err_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign sec         = shadow_q[0];
    assign min         = shadow_q[1];
    assign hour        = shadow_q[2];
    assign day         = shadow_q[3];
    assign month       = shadow_q[4];
    assign year        = shadow_q[5];
    assign t_sec       = shadow_q[6];
    assign t_min       = shadow_q[7];
    assign t_hour      = shadow_q[8];
    assign frame_valid = frame_valid_q;
    assign bcd_err     = bcd_err_q;
    assign seq_err     = seq_err_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_rtc_shadow_regs.sv
// tb/tb_rtc_shadow_regs.sv - self-checking bench for rtc_shadow_regs
module tb_rtc_shadow_regs;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] addr, data;
    logic       data_vld, abort;
    logic [7:0] sec, min, hour, day, month, year, t_sec, t_min, t_hour;
    logic       frame_valid, bcd_err, seq_err;
    logic [7:0] frame_cnt;

    typedef logic [8:0][7:0] frame_t;
    typedef struct packed {
        frame_t     f;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_cnt;
    int         checks = 0;
    int         errors = 0;

    rtc_shadow_regs dut (
        .clk(clk), .reset(reset), .addr(addr), .data(data), .data_vld(data_vld), .abort(abort),
        .sec(sec), .min(min), .hour(hour), .day(day), .month(month), .year(year),
        .t_sec(t_sec), .t_min(t_min), .t_hour(t_hour),
        .frame_valid(frame_valid), .bcd_err(bcd_err), .seq_err(seq_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic frame_t shadow_now();
        return {t_hour, t_min, t_sec, year, month, day, hour, min, sec};
    endfunction

    task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] addr_of(input int i);
        return (i < 6) ? 8'(8'h21 + i) : 8'(8'h41 + i - 6);
    endfunction

    function automatic logic [7:0] rand_bcd();
        return {4'($urandom_range(9)), 4'($urandom_range(9))};
    endfunction

    function automatic void push_exp(input frame_t f);
        exp_t e;
        model_cnt = model_cnt + 8'd1;
        e.f   = f;
        e.cnt = model_cnt;
        sb.push_back(e);
    endfunction

    // Scoreboard: every commit pulse must match the oldest expected frame
    always @(negedge clk) begin
        if (reset === 1'b1 && frame_valid === 1'b1) begin
            chk("commit_expected", 80'(sb.size() != 0), 80'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("commit_data", 80'(shadow_now()), 80'(e.f));
                chk("commit_cnt", 80'(frame_cnt), 80'(e.cnt));
            end
        end
    end

    task automatic strobe(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; data = d; data_vld = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            data_vld = 1'b0;
            abort    = 1'b0;
        end
    endtask

    task automatic send_range(input frame_t f, input int first, input int last);
        for (int i = first; i <= last; i++) strobe(addr_of(i), f[i]);
    endtask

    task automatic send_frame(input frame_t f, input logic good);
        if (good) push_exp(f);
        send_range(f, 0, 8);
        idle(1);
        chk("fv_early", 80'(frame_valid), 80'd0);
        @(negedge clk);
        chk("fv_latency", 80'(frame_valid), 80'(good));
        @(negedge clk);
        chk("fv_width", 80'(frame_valid), 80'd0);
    endtask

    frame_t fa, fb, fbad, fr;
    frame_t zero_f;
    logic [7:0] cnt_before;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        zero_f    = '0;
        fa        = {8'h01, 8'h05, 8'h10, 8'h24, 8'h07, 8'h25, 8'h12, 8'h30, 8'h45};
        fb        = {8'h59, 8'h58, 8'h57, 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h33};
        fbad      = fb;
        fbad[1]   = 8'h6A;
        fbad[0]   = 8'h11;
        model_cnt = 8'd0;
        reset = 1'b0; addr = 8'h00; data = 8'h00; data_vld = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_shadow", 80'(shadow_now()), 80'(zero_f));
        chk("rst_flags", 80'({frame_valid, bcd_err, seq_err}), 80'd0);
        chk("rst_cnt", 80'(frame_cnt), 80'd0);
        reset = 1'b1;
        idle(2);

        // Clean frame
        send_frame(fa, 1'b1);
        chk("clean_sec", 80'(sec), 80'h45);
        chk("clean_year", 80'(year), 80'h24);
        chk("clean_thour", 80'(t_hour), 80'h01);
        chk("clean_cnt", 80'(frame_cnt), 80'd1);
        chk("clean_flags", 80'({bcd_err, seq_err}), 80'd0);

        // Bad BCD: held outputs, sticky bcd_err, then cleared by a clean frame
        send_frame(fbad, 1'b0);
        chk("bad_bcd_err", 80'(bcd_err), 80'd1);
        chk("bad_hold", 80'(shadow_now()), 80'(fa));
        chk("bad_cnt", 80'(frame_cnt), 80'd1);
        send_frame(fb, 1'b1);
        chk("bcd_clr", 80'(bcd_err), 80'd0);
        chk("after_bad_data", 80'(shadow_now()), 80'(fb));

        // Out of order: 21,22,24 then rest ignored
        send_range(fa, 0, 1);
        strobe(8'h24, 8'h25);
        idle(1);
        chk("ooo_seq_err", 80'(seq_err), 80'd1);
        send_range(fa, 4, 8);
        idle(4);
        chk("ooo_cnt", 80'(frame_cnt), 80'd2);
        chk("ooo_hold", 80'(shadow_now()), 80'(fb));
        send_frame(fa, 1'b1);
        chk("seq_clr", 80'(seq_err), 80'd0);

        // Abort after 0x23: silent discard
        send_range(fb, 0, 2);
        @(negedge clk);
        data_vld = 1'b0; abort = 1'b1;
        idle(1);
        send_range(fb, 3, 8);
        idle(4);
        chk("abort_flags", 80'({bcd_err, seq_err}), 80'd0);
        chk("abort_cnt", 80'(frame_cnt), 80'd3);

        // Abort wins over a same-cycle strobe
        send_range(fb, 0, 7);
        @(negedge clk);
        addr = 8'h43; data = 8'h59; data_vld = 1'b1; abort = 1'b1;
        idle(4);
        chk("abort_prio_cnt", 80'(frame_cnt), 80'd3);

        // Timeout
        strobe(8'h21, 8'h00);
        idle(60);
        chk("tmo_not_yet", 80'(seq_err), 80'd0);
        idle(4);
        chk("tmo_seq_err", 80'(seq_err), 80'd1);
        send_range(fb, 1, 8);
        idle(4);
        chk("tmo_cnt", 80'(frame_cnt), 80'd3);

        // Restart on 0x21 mid-frame: seq_err set, new frame still commits
        send_range(fb, 0, 3);
        push_exp(fa);
        send_range(fa, 0, 8);
        idle(1);
        chk("restart_seq_err", 80'(seq_err), 80'd1);
        idle(3);
        chk("restart_data", 80'(shadow_now()), 80'(fa));
        chk("restart_seq_clr", 80'(seq_err), 80'd0);

        // Wrap frame_cnt back to 0
        while (model_cnt != 8'd0) begin
            for (int i = 0; i < 9; i++) fr[i] = rand_bcd();
            send_frame(fr, 1'b1);
        end
        chk("wrap_cnt", 80'(frame_cnt), 80'd0);

        // Reset between the 0x42 and 0x43 strobes
        send_frame(fa, 1'b1);
        cnt_before = frame_cnt;
        chk("pre_rst_cnt", 80'(cnt_before), 80'd1);
        send_range(fb, 0, 7);
        @(negedge clk);
        data_vld = 1'b0;
        reset    = 1'b0;
        #1;
        chk("midrst_shadow", 80'(shadow_now()), 80'(zero_f));
        chk("midrst_cnt", 80'(frame_cnt), 80'd0);
        chk("midrst_flags", 80'({frame_valid, bcd_err, seq_err}), 80'd0);
        model_cnt = 8'd0;
        @(negedge clk);
        reset = 1'b1;
        strobe(8'h43, 8'h59);
        idle(4);
        chk("post_rst_cnt", 80'(frame_cnt), 80'd0);
        chk("post_rst_shadow", 80'(shadow_now()), 80'(zero_f));

        chk("sb_empty", 80'(sb.size()), 80'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
